data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words stored; it SHALL be a power of two, 2..65536.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states between request acceptance and response; legal range is 0..15.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port mem_read, input, 1 bit, SHALL be the load request from the control path.
REQ-006 Port mem_write, input, 1 bit, SHALL be the store request from the control path.
REQ-007 Port addr, input, 32 bits, SHALL be the byte address (ALU result).
REQ-008 Port wdata, input, 32 bits, SHALL be the store data.
REQ-009 Port rdata, output, 32 bits, SHALL be the load data.
REQ-010 Port ready, output, 1 bit, SHALL be a one-cycle pulse marking request completion.
REQ-011 Port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.
REQ-012 Port err, output, 1 bit, SHALL be high only in the ready cycle of a faulted request.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE, a rising edge with mem_read or mem_write high SHALL accept the request and register addr, wdata and the request type.
REQ-015 On acceptance the FSM SHALL go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-016 A wait counter SHALL hold WAIT for exactly WAIT_CYCLES cycles, then enter RESP.
REQ-017 ready SHALL be high exactly in the RESP cycle, i.e. WAIT_CYCLES+1 cycles after the accepting edge; RESP SHALL always return to IDLE.
REQ-018 Requests present while busy is high SHALL be ignored; the requester need not hold inputs after acceptance.
REQ-019 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-020 A store SHALL update the array at the edge entering RESP.
REQ-021 A load SHALL drive the addressed word onto rdata in the RESP cycle; rdata SHALL hold that value until the next completed load.
REQ-022 mem_read and mem_write both high at acceptance SHALL be a fault: no array access, err=1 with ready, rdata unchanged.
REQ-023 Stores and faults SHALL NOT change rdata.
REQ-024 A load from an address stored by the immediately preceding request SHALL return the new data.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, zero the wait counter, and drive ready=0, busy=0, err=0, rdata=0.
REQ-026 Array contents SHALL NOT be reset.
REQ-027 Reset asserted in WAIT SHALL abort the pending request: a pending store SHALL NOT modify the array, and no ready pulse SHALL occur.
REQ-028 After rst_n rises, the first rising edge SHALL be able to accept a request.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN defined: addr[1:0]!=0 at acceptance SHALL be a fault handled as in REQ-022.
REQ-030 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored, and err SHALL assert only for the dual-request fault.

Verification
REQ-031 WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 accepted at edge 0 -> ready=1 only in cycle 3, err=0, busy=1 in cycles 1-2.
REQ-032 Load 0x10 after REQ-031 -> ready in cycle 3 with rdata=0xDEADBEEF; rdata still 0xDEADBEEF after a later store of 0x1 to 0x14.
REQ-033 DEPTH_WORDS=256: store 0x12345678 to 0x400 -> load of 0x0 returns 0x12345678 (wrap).
REQ-034 mem_read=mem_write=1 at 0x20 -> ready=1 with err=1, rdata unchanged, word 0x20 unchanged; with DMEM_ALIGN_CHECK_EN, load 0x22 -> err=1; without it, load 0x22 returns word 0x20.
REQ-035 Store 0xCAFEF00D to 0x8 with rst_n pulsed low during WAIT -> no ready, all outputs 0; subsequent load 0x8 returns prior contents (bench pre-writes 0x11111111 first).
REQ-036 WAIT_CYCLES=0: back-to-back loads held high -> ready every 2nd cycle, one cycle after each accepting edge.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data memory controller: word array behind a fixed-latency IDLE/WAIT/RESP request handshake.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned byte addresses become faulted requests.
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q;
   logic          accept, enter_resp;
   logic          live_fault;
   logic          rd_q, wr_q, fault_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic          req_rd, req_wr, req_fault;
   logic [AW-1:0] req_idx;
   logic [31:0]   req_wdata;
   logic          unused_addr;
   logic [31:0]   mem [DEPTH_WORDS];

`ifdef DMEM_ALIGN_CHECK_EN
   assign live_fault  = (mem_read & mem_write) | (addr[1:0] != 2'b00);
   assign unused_addr = ^addr[31:AW+2];
`else
   assign live_fault  = mem_read & mem_write;
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

   assign accept = rst_n & (state_q == IDLE) & (mem_read | mem_write);

   // With zero wait states the array is touched on the accepting edge itself,
   // so the request is taken straight from the ports while still in IDLE.
   assign req_rd    = (state_q == IDLE) ? mem_read   : rd_q;
   assign req_wr    = (state_q == IDLE) ? mem_write  : wr_q;
   assign req_fault = (state_q == IDLE) ? live_fault : fault_q;
   assign req_idx   = (state_q == IDLE) ? addr[AW+1:2] : idx_q;
   assign req_wdata = (state_q == IDLE) ? wdata      : wdata_q;

   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      err     = 1'b0;
      busy    = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
            ready   = 1'b1;
            err     = fault_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         fault_q <= 1'b0;
         rdata   <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q   <= WAIT_LOAD;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            fault_q <= live_fault;
         end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (enter_resp && req_rd && !req_fault) rdata <= mem[req_idx];
      end
   end

   // Request payload and array are plain data: never reset, so an aborted
   // store simply never reaches the write enable.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q   <= addr[AW+1:2];
         wdata_q <= wdata;
      end
      if (enter_resp && req_wr && !req_fault) mem[req_idx] <= req_wdata;
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: request-level timing/memory model plus directed literals.
module tb_data_mem_ctrl;

   localparam int WC    = 2;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        ready, busy, err;

   logic        rd0 = 1'b0, wr0 = 1'b0;
   logic [31:0] a0 = '0, d0 = '0;
   logic [31:0] rdata0;
   logic        ready0, busy0, err0;

   int          vectors = 0;
   int          fails = 0;
   int unsigned cyc = 0;

   bit          pend = 1'b0;
   bit          p_rd, p_wr;
   logic [31:0] p_addr, p_wdata;
   int          acc_cyc = 0;
   logic [31:0] mem_m [DEPTH];
   logic [31:0] exp_rdata = 32'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
   );

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0),
      .addr(a0), .wdata(d0), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_fault(bit rd, bit wr, logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
      return (rd && wr) || (a[1:0] != 2'b00);
`else
      return rd && wr;
`endif
   endfunction

   function automatic int word_of(logic [31:0] a);
      return int'((a % (DEPTH * 4)) / 4);
   endfunction

   // Model: a request accepted at some edge is busy for WC+1 cycles, the last being the response.
   always @(negedge clk) begin
      int k;
      bit e_busy, e_ready, e_err;
      if (!rst_n) begin
         exp_rdata = 32'd0;
         chk("rst_ready", {31'd0, ready}, 32'd0);
         chk("rst_busy",  {31'd0, busy},  32'd0);
         chk("rst_err",   {31'd0, err},   32'd0);
         chk("rst_rdata", rdata, 32'd0);
      end else begin
         k       = int'(cyc) - acc_cyc;
         e_busy  = pend && (k >= 0) && (k <= WC);
         e_ready = pend && (k == WC);
         e_err   = e_ready && is_fault(p_rd, p_wr, p_addr);
         if (e_ready && !e_err) begin
            if (p_rd) exp_rdata = mem_m[word_of(p_addr)];
            if (p_wr) mem_m[word_of(p_addr)] = p_wdata;
         end
         chk("ready", {31'd0, ready}, {31'd0, e_ready});
         chk("busy",  {31'd0, busy},  {31'd0, e_busy});
         chk("err",   {31'd0, err},   {31'd0, e_err});
         chk("rdata", rdata, exp_rdata);
      end
   end

   task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input bit finish);
      @(negedge clk);
      mem_read = rd; mem_write = wr; addr = a; wdata = d;
      @(posedge clk);
      #1;
      pend = 1'b1; p_rd = rd; p_wr = wr; p_addr = a; p_wdata = d; acc_cyc = int'(cyc);
      mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
      if (finish) begin
         repeat (WC + 1) @(negedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
      $fatal(1);
   end

   initial begin
      @(posedge clk); #2;
      chk("lit_reset_rdata", rdata, 32'd0);
      chk("lit_reset_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      req(0, 1, 32'h8, 32'h1111_1111, 1);

      // Store with hand-checked latency: busy right after acceptance, ready in the third cycle.
      req(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
      chk("lit_st_busy_k0", {31'd0, busy}, 32'd1);
      chk("lit_st_ready_k0", {31'd0, ready}, 32'd0);
      repeat (WC + 1) @(negedge clk);
      #1;
      chk("lit_st_ready_k2", {31'd0, ready}, 32'd1);
      chk("lit_st_err_k2", {31'd0, err}, 32'd0);

      req(1, 0, 32'h10, 32'h0, 1);
      chk("lit_ld_deadbeef", rdata, 32'hDEAD_BEEF);
      req(0, 1, 32'h14, 32'h1, 1);
      chk("lit_st_keeps_rdata", rdata, 32'hDEAD_BEEF);
      req(1, 0, 32'h14, 32'h0, 1);
      chk("lit_ld_one", rdata, 32'h1);

      req(0, 1, 32'h400, 32'h1234_5678, 1);
      req(1, 0, 32'h0, 32'h0, 1);
      chk("lit_wrap", rdata, 32'h1234_5678);
      req(0, 1, 32'h3FC, 32'h0BAD_F00D, 1);
      req(1, 0, 32'h7FC, 32'h0, 1);
      chk("lit_last_word", rdata, 32'h0BAD_F00D);

      req(0, 1, 32'h20, 32'h55AA_55AA, 1);
      req(1, 0, 32'h20, 32'h0, 1);
      req(1, 1, 32'h20, 32'hFFFF_FFFF, 1);
      chk("lit_fault_rdata", rdata, 32'h55AA_55AA);
      req(1, 0, 32'h14, 32'h0, 1);
      req(1, 0, 32'h20, 32'h0, 1);
      chk("lit_fault_word", rdata, 32'h55AA_55AA);
      req(1, 0, 32'h14, 32'h0, 1);
      req(1, 0, 32'h22, 32'h0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("lit_misaligned", rdata, 32'h1);
`else
      chk("lit_misaligned", rdata, 32'h55AA_55AA);
`endif

      // Reset during WAIT aborts the pending store.
      req(0, 1, 32'h8, 32'hCAFE_F00D, 0);
      #2 rst_n = 1'b0;
      pend = 1'b0;
      #1;
      chk("lit_abort_ready", {31'd0, ready}, 32'd0);
      chk("lit_abort_busy", {31'd0, busy}, 32'd0);
      chk("lit_abort_err", {31'd0, err}, 32'd0);
      chk("lit_abort_rdata", rdata, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      req(1, 0, 32'h8, 32'h0, 1);
      chk("lit_abort_prior", rdata, 32'h1111_1111);

      // Zero-wait instance: store, then a held load completes every second cycle.
      @(negedge clk);
      wr0 = 1'b1; a0 = 32'h4; d0 = 32'hA5A5_0001;
      @(negedge clk); #1;
      chk("w0_st_ready", {31'd0, ready0}, 32'd1);
      chk("w0_st_err", {31'd0, err0}, 32'd0);
      wr0 = 1'b0;
      @(negedge clk);
      rd0 = 1'b1; a0 = 32'h4;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         chk("w0_ld_ready", {31'd0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("w0_ld_busy", {31'd0, busy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("w0_ld_rdata", rdata0, 32'hA5A5_0001);
      end
      rd0 = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
